// File: rtl/therm2bin_pkg.sv
//------------------------------------------------------------------------------
// therm2bin_pkg
// Shared sizes, per-group summary type and group legality helper for the
// thermometer-to-binary encoder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package therm2bin_pkg;

    localparam int N    = 8;
    localparam int GW   = 16;
    localparam int TW   = 1 << N;
    localparam int NGRP = TW / GW;
    localparam int CW   = $clog2(GW) + 1;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          legal;
        logic          lsb;
        logic          msb;
    } grp_t;

    // A group is contiguous-from-LSB exactly when adding one clears every set bit.
    function automatic logic is_therm_group(input logic [GW-1:0] g);
        logic [GW-1:0] inc;
        inc = g + GW'(1);
        return ((g & inc) == '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/therm_group_count.sv
//------------------------------------------------------------------------------
// therm_group_count
// Combinational popcount and local legality summary for one GW-bit group.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module therm_group_count
    import therm2bin_pkg::*;
(
    input  logic [GW-1:0] grp_bits,
    output grp_t          info
);

    logic [CW-1:0] w_cnt;

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < GW; i++) begin
            w_cnt = w_cnt + CW'(grp_bits[i]);
        end
    end

    assign info.cnt   = w_cnt;
    assign info.legal = is_therm_group(grp_bits);
    assign info.lsb   = grp_bits[0];
    assign info.msb   = grp_bits[GW-1];

endmodule

`default_nettype wire

// File: rtl/therm2bin_encoder.sv
//------------------------------------------------------------------------------
// therm2bin_encoder
// Two-stage valid/ready thermometer-to-binary encoder with malformed-code flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module therm2bin_encoder #(
    parameter int N  = 8,
    parameter int GW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic [2**N-1:0] din,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic [N-1:0]    dout,
    output logic            err
);

    import therm2bin_pkg::grp_t;

    localparam int TW   = 2 ** N;
    localparam int NGRP = TW / GW;

    logic          w_adv;
    grp_t          w_grp    [NGRP];
    grp_t          r_s1_grp [NGRP];
    logic          r_s1_valid;
    logic [N:0]    w_sum;
    logic          w_bad;
    logic [N-1:0]  w_val;
    logic          r_dout_valid;
    logic [N-1:0]  r_dout;
    logic          r_err;

    assign w_adv     = !r_dout_valid || dout_ready;
    assign din_ready = w_adv;

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        therm_group_count u_cnt (
            .grp_bits (din[gi*GW +: GW]),
            .info     (w_grp[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= din_valid;
            // Data only captured for real words so X on an idle bus never lands here.
            if (din_valid) begin
                r_s1_grp <= w_grp;
            end
        end
    end

    // Every group contiguous plus no filled group sitting above a non-full one
    // is equivalent to the whole word being a legal thermometer code.
    always_comb begin
        w_sum = '0;
        w_bad = !r_s1_grp[0].lsb;
        for (int g = 0; g < NGRP; g++) begin
            w_sum = w_sum + (N+1)'(r_s1_grp[g].cnt);
            if (!r_s1_grp[g].legal) begin
                w_bad = 1'b1;
            end
        end
        for (int g = 1; g < NGRP; g++) begin
            if (r_s1_grp[g].lsb && !r_s1_grp[g-1].msb) begin
                w_bad = 1'b1;
            end
        end
    end

    assign w_val = (w_sum == '0) ? '0 : N'(w_sum - (N+1)'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
            r_err        <= 1'b0;
        end else if (w_adv) begin
            r_dout_valid <= r_s1_valid;
            r_dout       <= r_s1_valid ? w_val : '0;
            r_err        <= r_s1_valid ? w_bad : 1'b0;
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout       = r_dout;
    assign err        = r_err;

endmodule

`default_nettype wire
